adder_share_sched: RTL
======================

// Module: adder_share_sched
// PURPOSE
// - Shares the single WIDTH-bit adder datapath (sum = a + b) between NREQ requesters.
// - Round-robin arbitration with valid/ready handshakes; one-entry registered result stage.
// - Sits between requester logic (pin front-ends, test sequencers) and the top-level output mux.
// - Also keeps a saturating backpressure-stall counter for debug readout.
// PARAMETERS
// - NREQ   4   number of requesters, 2..8
// - WIDTH  8   operand/result width
// - CNTW   16  stall counter width
// PORTS
// - clk         in   1           clock; single clock domain
// - rst         in   1           reset; synchronous, active-high
// - req_valid   in   NREQ        requester i has operands ready
// - req_ready   out  NREQ        one-hot grant; handshake when req_valid[i] & req_ready[i]
// - req_a       in   NREQ*WIDTH  operand A, requester i at [i*WIDTH +: WIDTH]
// - req_b       in   NREQ*WIDTH  operand B, same packing
// - rsp_valid   out  1           result register holds a valid result
// - rsp_ready   in   1           consumer accepts the result
// - rsp_sum     out  WIDTH       (a + b) mod 2^WIDTH
// - rsp_carry   out  1           carry-out of a + b
// - rsp_id      out  IDW         index of the requester that produced the result (IDW = clog2(NREQ))
// - stall_cnt   out  CNTW        cycles with rsp_valid & !rsp_ready; saturates at all-ones
// BEHAVIOUR
// - Reset values: req_ready = 0, rsp_valid = 0, rsp_sum = 0, rsp_carry = 0, rsp_id = 0,
//   stall_cnt = 0, rr_ptr = 0.
// - States: EMPTY (rsp_valid = 0) and FULL (rsp_valid = 1).
// - can_accept = !rsp_valid | rsp_ready. This is a combinational pass-through of rsp_ready
//   to req_ready; no bubble under continuous streaming.
// - Grant (combinational):
//   - Only when can_accept = 1.
//   - Picks the first i with req_valid[i], searching rr_ptr, rr_ptr+1, ..., wrapping modulo NREQ.
//   - At most one req_ready bit is high. req_ready is all-zero when can_accept = 0 or no request.
//   - req_ready never depends on req_a or req_b.
// - On a grant to i at edge t:
//   - rsp_sum, rsp_carry and rsp_id load {carry, sum} = a_i + b_i (WIDTH+1-bit add) and id = i.
//   - rsp_valid = 1 after edge t. Latency is exactly 1 cycle.
//   - rr_ptr <= (i + 1) mod NREQ.
// - No grant and rsp_ready = 1 in FULL: rsp_valid <= 0. Data registers hold their last value.
// - FULL with rsp_ready = 0: rsp_* are held stable; req_ready = 0.
// - rr_ptr changes only on a grant. Idle cycles do not rotate priority.
// - Simultaneous drain and grant (FULL, rsp_ready = 1, req pending): the new result replaces
//   the old one in the same edge; rsp_valid stays 1.
// - stall_cnt increments by 1 at each edge where rsp_valid & !rsp_ready. It holds at 2^CNTW-1
//   and clears only on rst.
// - Requesters may drop req_valid without a handshake. The block holds no per-requester state
//   besides rr_ptr.
// - rst asserted mid-transaction: the pending result is discarded; all registers return to
//   reset values at that edge. req_ready = 0 while rst = 1.
// - Fairness: a continuously asserting requester is granted within NREQ grants.
// STRUCTURE
// - Shared package adder_sched_pkg:
//   - localparams NREQ_DEF = 4, WIDTH_DEF = 8, CNTW_DEF = 16.
//   - function clog2_min1(n), which returns at least 1.
//   - state encoding localparams ST_EMPTY = 1'b0, ST_FULL = 1'b1.
// - One sub-module, rr_arbiter:
//   - Parameter N.
//   - Ports: req[N], en, ptr[IDW] in; gnt[N] one-hot, gnt_id[IDW], gnt_any out.
//   - Purely combinational; rr_ptr register stays in the parent.
// - Parent holds: operand mux (selected by gnt_id), WIDTH+1 adder, result register,
//   FSM bit, rr_ptr, stall counter.
// TESTING
// - Reset: hold rst 2 cycles with all req_valid = 1 -> req_ready = 0, rsp_valid = 0,
//   stall_cnt = 0 throughout.
// - Single op: req 0 with a = 8'hF0, b = 8'h20, rsp_ready = 1
//   -> next cycle rsp_valid = 1, rsp_sum = 8'h10, rsp_carry = 1, rsp_id = 0.
// - Round-robin: req_valid = 4'b1111 and rsp_ready = 1 for 8 cycles
//   -> grant ids 0,1,2,3,0,1,2,3 and rsp_valid held high with no bubbles.
// - Backpressure: rsp_ready = 0 for 5 cycles while FULL -> rsp_* stable, req_ready = 0,
//   stall_cnt = 5; then rsp_ready = 1 -> stall_cnt stays 5.
// - Skip and wrap: after a grant to 3, only req 1 and req 2 valid -> grant 1, then 2.
//   With CNTW = 3, 10 stall cycles -> stall_cnt = 7 (saturated).
// - Reset mid-op: FULL with rsp_ready = 0, assert rst for 1 cycle -> rsp_valid = 0 and
//   rr_ptr = 0; the next all-valid request grants id 0.

Source files
------------

// File: rtl/adder_sched_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | adder_sched_pkg: shared defaults, sizing helper, result-stage states.    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package adder_sched_pkg;

  localparam int NREQ_DEF  = 4;
  localparam int WIDTH_DEF = 8;
  localparam int CNTW_DEF  = 16;

  localparam logic ST_EMPTY = 1'b0;
  localparam logic ST_FULL  = 1'b1;

  // Index width for n items; never zero so single-bit ids stay legal.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    for (int k = 0; k < 31; k++) begin
      if ((1 << k) < n) r = k + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/adder_share_sched_rr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rr_arbiter: combinational round-robin picker starting the search at ptr. |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module rr_arbiter
  import adder_sched_pkg::*;
#(
  parameter int N = NREQ_DEF,
  localparam int IDW = clog2_min1(N)
) (
  input  logic [N-1:0]   req,
  input  logic           en,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_id,
  output logic           gnt_any
);

  logic [IDW:0]   w_cand;
  logic [IDW-1:0] w_idx;

  always_comb begin
    gnt     = '0;
    gnt_id  = '0;
    gnt_any = 1'b0;
    w_cand  = '0;
    w_idx   = '0;
    for (int off = 0; off < N; off++) begin
      // ptr is always below N, so one conditional subtract implements the wrap.
      w_cand = {1'b0, ptr} + (IDW+1)'(off);
      if (w_cand >= (IDW+1)'(N)) w_cand = w_cand - (IDW+1)'(N);
      w_idx = w_cand[IDW-1:0];
      if (en && !gnt_any && req[w_idx]) begin
        gnt[w_idx] = 1'b1;
        gnt_id     = w_idx;
        gnt_any    = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/adder_share_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | adder_share_sched: one WIDTH-bit adder shared by NREQ requesters with    |
// | round-robin grant, one-entry result register and a stall counter.       |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module adder_share_sched
  import adder_sched_pkg::*;
#(
  parameter int NREQ  = NREQ_DEF,
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNTW  = CNTW_DEF,
  localparam int IDW  = clog2_min1(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WIDTH-1:0]      rsp_sum,
  output logic                  rsp_carry,
  output logic [IDW-1:0]        rsp_id,
  output logic [CNTW-1:0]       stall_cnt
);

  logic             r_state;
  logic [IDW-1:0]   r_rr_ptr;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic [IDW-1:0]   r_id;
  logic [CNTW-1:0]  r_stall;

  logic             w_can_accept;
  logic             w_arb_en;
  logic [NREQ-1:0]  w_gnt;
  logic [IDW-1:0]   w_gnt_id;
  logic             w_gnt_any;
  logic [WIDTH-1:0] w_sel_a;
  logic [WIDTH-1:0] w_sel_b;
  logic [WIDTH:0]   w_add;
  logic [IDW-1:0]   w_ptr_next;

  assign rsp_valid    = (r_state == ST_FULL);
  // rsp_ready passes straight through so a streaming consumer sees no bubble.
  assign w_can_accept = !rsp_valid || rsp_ready;
  assign w_arb_en     = w_can_accept && !rst;

  rr_arbiter #(
    .N (NREQ)
  ) u_arb (
    .req     (req_valid),
    .en      (w_arb_en),
    .ptr     (r_rr_ptr),
    .gnt     (w_gnt),
    .gnt_id  (w_gnt_id),
    .gnt_any (w_gnt_any)
  );

  assign req_ready = w_gnt;

  always_comb begin
    w_sel_a = '0;
    w_sel_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_gnt_id == IDW'(i)) begin
        w_sel_a = req_a[i*WIDTH +: WIDTH];
        w_sel_b = req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  assign w_add      = {1'b0, w_sel_a} + {1'b0, w_sel_b};
  assign w_ptr_next = (w_gnt_id == IDW'(NREQ-1)) ? '0 : w_gnt_id + IDW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_EMPTY;
      r_rr_ptr <= '0;
      r_sum    <= '0;
      r_carry  <= 1'b0;
      r_id     <= '0;
      r_stall  <= '0;
    end else begin
      if (w_gnt_any) begin
        r_state  <= ST_FULL;
        r_sum    <= w_add[WIDTH-1:0];
        r_carry  <= w_add[WIDTH];
        r_id     <= w_gnt_id;
        r_rr_ptr <= w_ptr_next;
      end else if (rsp_ready) begin
        r_state <= ST_EMPTY;
      end
      if (rsp_valid && !rsp_ready && (r_stall != {CNTW{1'b1}})) begin
        r_stall <= r_stall + CNTW'(1);
      end
    end
  end

  assign rsp_sum   = r_sum;
  assign rsp_carry = r_carry;
  assign rsp_id    = r_id;
  assign stall_cnt = r_stall;

endmodule
`default_nettype wire
